// File: rtl/pixel_scan_controller.sv
// Frame scan sequencer: read pixel, run colour pipeline for PIPE_LAT cycles, write back, advance.
// Optional abort support is compiled in with `define PIXEL_SCAN_ABORT_EN.
module pixel_scan_controller #(
  parameter int ADDR_BITS = 16,
  parameter int COL_BITS  = 10,
  parameter int ROW_BITS  = 10,
  parameter int PIPE_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COL_BITS-1:0]  last_col,
  input  logic [ROW_BITS-1:0]  last_row,
  input  logic [ADDR_BITS-1:0] rd_base,
  input  logic [ADDR_BITS-1:0] wr_base,
  output logic                 mem_rd_req,
  output logic                 mem_wr_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_ack,
  output logic                 pix_start,
  output logic                 pix_capture,
  output logic                 busy,
  output logic                 row_done,
  output logic                 frame_done
`ifdef PIXEL_SCAN_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_PROC, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(PIPE_LAT - 1);

  state_t               r_state, w_next;
  logic [COL_BITS-1:0]  r_lastCol, r_col;
  logic [ROW_BITS-1:0]  r_lastRow, r_row;
  logic [ADDR_BITS-1:0] r_rdBase, r_wrBase, r_offset;
  logic [3:0]           r_lat;

  logic w_lastPix, w_lastFrame, w_latDone;
  logic w_abortNow, w_abortAfterWrite;

  assign w_lastPix   = (r_col == r_lastCol);
  assign w_lastFrame = w_lastPix && (r_row == r_lastRow);
  assign w_latDone   = (r_lat == LAT_LAST);

`ifdef PIXEL_SCAN_ABORT_EN
  logic r_abortPend, r_aborted;

  // A write that is already on the bus must finish, so abort during WRITE is deferred until the ack.
  assign w_abortNow        = abort && (r_state inside {S_READ, S_PROC, S_ADVANCE});
  assign w_abortAfterWrite = (r_state == S_WRITE) && (abort || r_abortPend);
  assign aborted           = r_aborted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_abortPend <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_abortPend <= (r_state == S_WRITE) && !mem_ack && (abort || r_abortPend);
      r_aborted   <= w_abortNow || (w_abortAfterWrite && mem_ack);
    end
  end
`else
  assign w_abortNow        = 1'b0;
  assign w_abortAfterWrite = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_READ;
      S_READ:    if (w_abortNow) w_next = S_IDLE;
                 else if (mem_ack) w_next = S_PROC;
      S_PROC:    if (w_abortNow) w_next = S_IDLE;
                 else if (w_latDone) w_next = S_WRITE;
      S_WRITE:   if (mem_ack) w_next = w_abortAfterWrite ? S_IDLE : S_ADVANCE;
      S_ADVANCE: if (w_abortNow) w_next = S_IDLE;
                 else w_next = w_lastFrame ? S_DONE : S_READ;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_req  = (r_state == S_READ);
    mem_wr_req  = (r_state == S_WRITE);
    mem_addr    = '0;
    if (r_state == S_READ)  mem_addr = r_rdBase + r_offset;
    if (r_state == S_WRITE) mem_addr = r_wrBase + r_offset;
    pix_start   = (r_state == S_PROC) && (r_lat == 4'd0);
    pix_capture = (r_state == S_PROC) && w_latDone;
    busy        = (r_state != S_IDLE);
    row_done    = (r_state == S_ADVANCE) && w_lastPix && !w_abortNow;
    frame_done  = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lastCol <= '0;
      r_lastRow <= '0;
      r_rdBase  <= '0;
      r_wrBase  <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_offset  <= '0;
      r_lat     <= '0;
    end else begin
      r_state <= w_next;
      r_lat   <= (r_state == S_PROC && !w_latDone) ? r_lat + 4'd1 : 4'd0;
      if (r_state == S_IDLE && start) begin
        r_lastCol <= last_col;
        r_lastRow <= last_row;
        r_rdBase  <= rd_base;
        r_wrBase  <= wr_base;
        r_col     <= '0;
        r_row     <= '0;
        r_offset  <= '0;
      end
      // Column wraps to zero at the row end; the row counter only moves when the frame continues.
      if (r_state == S_ADVANCE) begin
        r_offset <= r_offset + 1'b1;
        if (w_lastPix) begin
          r_col <= '0;
          if (!w_lastFrame) r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Directed self-checking bench for pixel_scan_controller (default build, PIPE_LAT=3).
module tb_pixel_scan_controller;

  logic        clk = 1'b0;
  logic        rst, start, mem_ack;
  logic [9:0]  last_col, last_row;
  logic [15:0] rd_base, wr_base, mem_addr;
  logic        mem_rd_req, mem_wr_req, pix_start, pix_capture, busy, row_done, frame_done;

  int errors = 0;
  int checks = 0;

  int ackDelay = 0;
  bit tieHigh  = 1'b1;
  int waitCnt  = 0;

  int cycleCnt = 0, startCycle = 0, frameDoneCycle = 0, rowDoneCycle = 0;
  int rowDoneCnt, frameDoneCnt, pixStartCnt, pixCaptureCnt, stabErr, bothErr;
  logic [15:0] rdLog[$];
  logic [15:0] wrLog[$];
  logic        prevReq = 1'b0, prevAck = 1'b0, prevRst = 1'b1, prevRd = 1'b0, prevWr = 1'b0;
  logic [15:0] prevAddr = '0;

  pixel_scan_controller #(.ADDR_BITS(16), .COL_BITS(10), .ROW_BITS(10), .PIPE_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .last_col(last_col), .last_row(last_row),
    .rd_base(rd_base), .wr_base(wr_base), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .pix_start(pix_start), .pix_capture(pix_capture),
    .busy(busy), .row_done(row_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after ackDelay waiting cycles; tieHigh sets ack level with no request.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_req || mem_wr_req) begin
        if (waitCnt >= ackDelay) begin
          mem_ack = 1'b1;
          waitCnt = 0;
        end else begin
          mem_ack = 1'b0;
          waitCnt++;
        end
      end else begin
        mem_ack = tieHigh;
        waitCnt = 0;
      end
    end
  end

  // Observer: logs accepted addresses and pulses, and tracks request stability between samples.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cycleCnt++;
      if (start && !busy && !rst) startCycle = cycleCnt;
      if (mem_rd_req && mem_wr_req) bothErr++;
      if (prevReq && !prevAck && !prevRst)
        if (mem_rd_req !== prevRd || mem_wr_req !== prevWr || mem_addr !== prevAddr) stabErr++;
      if (mem_rd_req && mem_ack) rdLog.push_back(mem_addr);
      if (mem_wr_req && mem_ack) wrLog.push_back(mem_addr);
      if (row_done) begin rowDoneCnt++; rowDoneCycle = cycleCnt; end
      if (frame_done) begin frameDoneCnt++; frameDoneCycle = cycleCnt; end
      if (pix_start) pixStartCnt++;
      if (pix_capture) pixCaptureCnt++;
      prevReq  = mem_rd_req || mem_wr_req;
      prevRd   = mem_rd_req;
      prevWr   = mem_wr_req;
      prevAck  = mem_ack;
      prevRst  = rst;
      prevAddr = mem_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearLogs();
    rdLog.delete();
    wrLog.delete();
    rowDoneCnt = 0; frameDoneCnt = 0; pixStartCnt = 0; pixCaptureCnt = 0;
    stabErr = 0; bothErr = 0;
  endtask

  task automatic startFrame(input logic [9:0] lc, input logic [9:0] lr,
                            input logic [15:0] rb, input logic [15:0] wb);
    @(negedge clk);
    last_col = lc; last_row = lr; rd_base = rb; wr_base = wb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitFrame(output bit done);
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frameDoneCnt > 0) begin done = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; last_col = '0; last_row = '0; rd_base = '0; wr_base = '0;
    tieHigh = 1'b1; ackDelay = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clearLogs();
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if ({busy, mem_rd_req, mem_wr_req, mem_addr, pix_start, pix_capture, row_done, frame_done} !== 23'd0)
      begin errors++; $display("[TB] FAIL reset_outputs got busy=%b rd=%b wr=%b addr=%h want all 0",
                               busy, mem_rd_req, mem_wr_req, mem_addr); end
    checks++;
    if (rdLog.size() + wrLog.size() + frameDoneCnt !== 0)
      begin errors++; $display("[TB] FAIL idle_ack_ignored got %0d events want 0",
                               rdLog.size() + wrLog.size() + frameDoneCnt); end
  endtask

  task automatic test_basic_frame();
    bit done;
    clearLogs();
    ackDelay = 0; tieHigh = 1'b1;
    startFrame(10'd1, 10'd1, 16'h0100, 16'h8000);
    waitFrame(done);
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL basic_timeout got no frame_done want frame_done"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rdLog.size() || rdLog[i] !== 16'(16'h0100 + i))
        begin errors++; $display("[TB] FAIL basic_rd[%0d] got %h want %h", i,
                                 (i < rdLog.size()) ? rdLog[i] : 16'hxxxx, 16'(16'h0100 + i)); end
      checks++;
      if (i >= wrLog.size() || wrLog[i] !== 16'(16'h8000 + i))
        begin errors++; $display("[TB] FAIL basic_wr[%0d] got %h want %h", i,
                                 (i < wrLog.size()) ? wrLog[i] : 16'hxxxx, 16'(16'h8000 + i)); end
    end
    checks++;
    if (rdLog.size() !== 4 || wrLog.size() !== 4)
      begin errors++; $display("[TB] FAIL basic_count got rd=%0d wr=%0d want 4/4", rdLog.size(), wrLog.size()); end
    checks++;
    if (rowDoneCnt !== 2) begin errors++; $display("[TB] FAIL basic_row_done got %0d want 2", rowDoneCnt); end
    checks++;
    if (frameDoneCycle - startCycle !== 25)
      begin errors++; $display("[TB] FAIL basic_latency got %0d want 25", frameDoneCycle - startCycle); end
    checks++;
    if (frameDoneCnt !== 1) begin errors++; $display("[TB] FAIL basic_frame_done got %0d want 1", frameDoneCnt); end
    checks++;
    if (pixStartCnt !== 4 || pixCaptureCnt !== 4)
      begin errors++; $display("[TB] FAIL basic_pix got %0d/%0d want 4/4", pixStartCnt, pixCaptureCnt); end
    checks++;
    if (bothErr !== 0) begin errors++; $display("[TB] FAIL basic_rd_wr_overlap got %0d want 0", bothErr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_ack_delay();
    bit done;
    clearLogs();
    ackDelay = 4; tieHigh = 1'b0;
    startFrame(10'd1, 10'd0, 16'h0040, 16'h0080);
    waitFrame(done);
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL delay_timeout got no frame_done want frame_done"); end
    checks++;
    if (frameDoneCycle - startCycle !== 29)
      begin errors++; $display("[TB] FAIL delay_latency got %0d want 29", frameDoneCycle - startCycle); end
    checks++;
    if (stabErr !== 0) begin errors++; $display("[TB] FAIL delay_req_stable got %0d changes want 0", stabErr); end
    checks++;
    if (pixStartCnt !== 2 || pixCaptureCnt !== 2)
      begin errors++; $display("[TB] FAIL delay_pix got %0d/%0d want 2/2", pixStartCnt, pixCaptureCnt); end
    checks++;
    if (rdLog.size() !== 2 || rdLog[0] !== 16'h0040 || rdLog[1] !== 16'h0041)
      begin errors++; $display("[TB] FAIL delay_rd got %0d reads want 0040,0041", rdLog.size()); end
    checks++;
    if (wrLog.size() !== 2 || wrLog[0] !== 16'h0080 || wrLog[1] !== 16'h0081)
      begin errors++; $display("[TB] FAIL delay_wr got %0d writes want 0080,0081", wrLog.size()); end
    checks++;
    if (bothErr !== 0) begin errors++; $display("[TB] FAIL delay_rd_wr_overlap got %0d want 0", bothErr); end
    ackDelay = 0; tieHigh = 1'b1;
  endtask

  task automatic test_single_pixel();
    bit done;
    clearLogs();
    startFrame(10'd0, 10'd0, 16'h1234, 16'h4321);
    waitFrame(done);
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL single_timeout got no frame_done want frame_done"); end
    checks++;
    if (rdLog.size() !== 1 || rdLog[0] !== 16'h1234)
      begin errors++; $display("[TB] FAIL single_rd got %0d reads want one at 1234", rdLog.size()); end
    checks++;
    if (wrLog.size() !== 1 || wrLog[0] !== 16'h4321)
      begin errors++; $display("[TB] FAIL single_wr got %0d writes want one at 4321", wrLog.size()); end
    checks++;
    if (rowDoneCnt !== 1 || frameDoneCnt !== 1)
      begin errors++; $display("[TB] FAIL single_pulses got row=%0d frame=%0d want 1/1", rowDoneCnt, frameDoneCnt); end
    checks++;
    if (frameDoneCycle !== rowDoneCycle + 1)
      begin errors++; $display("[TB] FAIL single_order got gap %0d want 1", frameDoneCycle - rowDoneCycle); end
    checks++;
    if (frameDoneCycle - startCycle !== 7)
      begin errors++; $display("[TB] FAIL single_latency got %0d want 7", frameDoneCycle - startCycle); end
  endtask

  task automatic test_reset_midframe();
    bit done;
    bit reached;
    clearLogs();
    startFrame(10'd1, 10'd1, 16'h0200, 16'h9000);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pixStartCnt >= 2) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin errors++; $display("[TB] FAIL midrst_reach got %0d pix_start want 2", pixStartCnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if ({busy, mem_rd_req, mem_wr_req, mem_addr, pix_start, pix_capture, row_done, frame_done} !== 23'd0)
      begin errors++; $display("[TB] FAIL midrst_outputs got busy=%b rd=%b wr=%b addr=%h pix=%b%b want all 0",
                               busy, mem_rd_req, mem_wr_req, mem_addr, pix_start, pix_capture); end
    checks++;
    if (frameDoneCnt !== 0) begin errors++; $display("[TB] FAIL midrst_no_frame_done got %0d want 0", frameDoneCnt); end
    clearLogs();
    startFrame(10'd1, 10'd1, 16'h0200, 16'h9000);
    waitFrame(done);
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL midrst_timeout got no frame_done want frame_done"); end
    checks++;
    if (rdLog.size() !== 4 || rdLog[0] !== 16'h0200 || rdLog[3] !== 16'h0203)
      begin errors++; $display("[TB] FAIL midrst_restart_rd got %0d reads want 0200..0203", rdLog.size()); end
    checks++;
    if (wrLog.size() !== 4 || wrLog[0] !== 16'h9000)
      begin errors++; $display("[TB] FAIL midrst_restart_wr got %0d writes want from 9000", wrLog.size()); end
    checks++;
    if (frameDoneCycle - startCycle !== 25)
      begin errors++; $display("[TB] FAIL midrst_latency got %0d want 25", frameDoneCycle - startCycle); end
  endtask

  task automatic test_busy_ignored();
    bit done;
    clearLogs();
    startFrame(10'd1, 10'd1, 16'h0100, 16'h8000);
    repeat (5) @(negedge clk);
    start = 1'b1; rd_base = 16'h5555; wr_base = 16'h7777; last_col = 10'd0; last_row = 10'd0;
    @(negedge clk);
    start = 1'b0;
    waitFrame(done);
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL busy_timeout got no frame_done want frame_done"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rdLog.size() || rdLog[i] !== 16'(16'h0100 + i))
        begin errors++; $display("[TB] FAIL busy_rd[%0d] got %h want %h", i,
                                 (i < rdLog.size()) ? rdLog[i] : 16'hxxxx, 16'(16'h0100 + i)); end
    end
    checks++;
    if (wrLog.size() !== 4 || wrLog[3] !== 16'h8003)
      begin errors++; $display("[TB] FAIL busy_wr got %0d writes want 8000..8003", wrLog.size()); end
    checks++;
    if (rowDoneCnt !== 2 || frameDoneCycle - startCycle !== 25)
      begin errors++; $display("[TB] FAIL busy_shape got rows=%0d latency=%0d want 2/25",
                               rowDoneCnt, frameDoneCycle - startCycle); end
  endtask

  task automatic test_wrap();
    bit done;
    logic [15:0] expRd[4];
    logic [15:0] expWr[4];
    expRd[0] = 16'hFFFE; expRd[1] = 16'hFFFF; expRd[2] = 16'h0000; expRd[3] = 16'h0001;
    expWr[0] = 16'hFFFF; expWr[1] = 16'h0000; expWr[2] = 16'h0001; expWr[3] = 16'h0002;
    clearLogs();
    startFrame(10'd3, 10'd0, 16'hFFFE, 16'hFFFF);
    waitFrame(done);
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL wrap_timeout got no frame_done want frame_done"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rdLog.size() || rdLog[i] !== expRd[i])
        begin errors++; $display("[TB] FAIL wrap_rd[%0d] got %h want %h", i,
                                 (i < rdLog.size()) ? rdLog[i] : 16'hxxxx, expRd[i]); end
      checks++;
      if (i >= wrLog.size() || wrLog[i] !== expWr[i])
        begin errors++; $display("[TB] FAIL wrap_wr[%0d] got %h want %h", i,
                                 (i < wrLog.size()) ? wrLog[i] : 16'hxxxx, expWr[i]); end
    end
    checks++;
    if (rowDoneCnt !== 1 || frameDoneCycle - startCycle !== 25)
      begin errors++; $display("[TB] FAIL wrap_shape got rows=%0d latency=%0d want 1/25",
                               rowDoneCnt, frameDoneCycle - startCycle); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    last_col = '0; last_row = '0; rd_base = '0; wr_base = '0;
    test_reset();
    test_basic_frame();
    test_ack_delay();
    test_single_pixel();
    test_reset_midframe();
    test_busy_ignored();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_scan_controller.md
Name: pixel_scan_controller

Overview:
- Frame-level sequencer for the daltonization datapath.
- Walks a rectangular pixel region column by column and row by row, and fetches each pixel from frame memory over a req/ack interface.
- Starts the color pipeline for each pixel and waits its fixed latency, then writes the result back to memory.
- Uses internal rollover counters (column, row, latency wait) and reports row and frame completion to the top-level control.

Parameters:
- ADDR_BITS, 16, width of memory addresses and of the linear pixel offset.
- COL_BITS, 10, width of the column counter and of last_col.
- ROW_BITS, 10, width of the row counter and of last_row.
- PIPE_LAT, 3, color pipeline latency in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin frame; sampled only in IDLE.
- last_col  in  COL_BITS  index of last column (row width minus 1).
- last_row  in  ROW_BITS  index of last row (frame height minus 1).
- rd_base  in  ADDR_BITS  source frame base address.
- wr_base  in  ADDR_BITS  destination frame base address.
- mem_rd_req  out  1  memory read request.
- mem_wr_req  out  1  memory write request.
- mem_addr  out  ADDR_BITS  address for the active request; 0 when no request is active.
- mem_ack  in  1  memory accepts the current request in this cycle.
- pix_start  out  1  one-cycle pulse: read data valid, pipeline may load it.
- pix_capture  out  1  one-cycle pulse: pipeline result valid, latch it as write data.
- busy  out  1  high in every state except IDLE.
- row_done  out  1  one-cycle pulse at end of each row.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: rst high at a clock edge forces IDLE and clears all counters and the offset. All outputs are 0 in the following cycle, including mid-transaction; outstanding requests drop with no completion.
- Latching: start=1 in IDLE latches last_col, last_row, rd_base and wr_base, clears col, row and offset, and moves to READ.
  - Inputs changing while busy have no effect.
  - start while busy is ignored.
- States:
  - IDLE: wait for start.
  - READ: mem_rd_req=1, mem_addr=rd_base+offset. Hold until mem_ack=1, then go to PROC.
  - PROC: lasts exactly PIPE_LAT cycles, counted by the latency counter.
    - pix_start=1 in the first PROC cycle; pix_capture=1 in the last PROC cycle.
    - With PIPE_LAT=1, both pulse in the same cycle.
    - Then go to WRITE.
  - WRITE: mem_wr_req=1, mem_addr=wr_base+offset. Hold until mem_ack=1, then go to ADVANCE.
  - ADVANCE: exactly one cycle; offset increments.
    - If col==last_col: col is cleared and row_done=1.
      - If row==last_row as well, go to DONE.
      - Otherwise row increments and the next state is READ.
    - Otherwise col increments and the next state is READ.
  - DONE: frame_done=1 for one cycle, then IDLE.
- Requests:
  - mem_rd_req and mem_wr_req are never high together.
  - A request stays high, with a stable address, until acked.
  - mem_ack in any cycle without an active request is ignored.
- Arithmetic: address sums and the offset wrap modulo 2^ADDR_BITS with no error flag.
- Degenerate frame: last_col=0 and last_row=0 processes exactly one pixel.
- Timing: with mem_ack tied high, each pixel takes PIPE_LAT+3 cycles. frame_done is high N·(PIPE_LAT+3)+1 cycles after the edge that samples start, where N is the pixel count.

Optional Feature:
- Macro: PIXEL_SCAN_ABORT_EN.
- When defined, two ports are added: input abort (1) and output aborted (1-cycle pulse).
- abort=1 sampled in READ, PROC or ADVANCE:
  - Go to IDLE next cycle and pulse aborted.
  - mem_rd_req drops immediately.
  - No row_done or frame_done is pulsed.
- abort=1 sampled in WRITE: the write completes first (wait for mem_ack), then go to IDLE and pulse aborted.
- abort in IDLE or DONE is ignored; DONE still pulses frame_done.
- When not defined, the ports do not exist and abort logic is absent.

Test Plan:
- Reset, then start with last_col=1, last_row=1, rd_base=0x0100, wr_base=0x8000, PIPE_LAT=3, mem_ack tied 1:
  - Read addresses are 0x0100..0x0103 and write addresses are 0x8000..0x8003, in order.
  - row_done pulses twice.
  - frame_done is high exactly 25 cycles after start is sampled.
- mem_ack delayed 4 cycles on every request:
  - mem_rd_req and mem_wr_req hold steady with a constant mem_addr.
  - Per-pixel time rises to 14 cycles (PIPE_LAT=3); pix_start and pix_capture each pulse once per pixel.
- last_col=0, last_row=0:
  - Exactly one read and one write occur.
  - row_done and frame_done both pulse: row_done in ADVANCE, frame_done one cycle later.
- rst asserted in PROC of pixel 2, then start again:
  - All outputs are 0 the next cycle and busy=0.
  - The new frame restarts at offset 0.
- start pulsed while busy, and rd_base changed mid-frame: no effect; the addresses continue from the latched base.
- rd_base=0xFFFE, last_col=3, last_row=0: read addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
